// File: rtl/nn_param_update_calc.sv
// nn_param_update_calc: stochastic-gradient parameter update engine.
// Flow: START captures the parameter, a 2^LOG2_WINDOW-cycle window integrates
// GRAD_POS - GRAD_NEG, one cycle computes the new magnitude/sign/resistance,
// then TRIG/DONE strobe for one cycle so the parameter register can latch them.
// Ports:
//   i_clk, i_init (async active-high reset), i_en (global enable/freeze)
//   i_start, i_grad_pos, i_grad_neg
//   i_param_in, i_sign_in, i_resistance_in   current latched parameter
//   o_modifier, o_sign_modifier, o_resistance_new   registered update result
//   o_trig, o_done (one-cycle strobe), o_busy (not IDLE)
module nn_param_update_calc #(
    parameter int N            = 8,
    parameter int N_RESISTANCE = 8,
    parameter int LOG2_WINDOW  = 8
) (
    input  logic                    i_clk,
    input  logic                    i_init,
    input  logic                    i_en,
    input  logic                    i_start,
    input  logic                    i_grad_pos,
    input  logic                    i_grad_neg,
    input  logic [N-1:0]            i_param_in,
    input  logic                    i_sign_in,
    input  logic [N_RESISTANCE-1:0] i_resistance_in,
    output logic [N-1:0]            o_modifier,
    output logic                    o_sign_modifier,
    output logic [N_RESISTANCE-1:0] o_resistance_new,
    output logic                    o_trig,
    output logic                    o_busy,
    output logic                    o_done
);
    localparam int AW = LOG2_WINDOW + 2;
    // wide enough for |acc|, the parameter and their unsaturated sum
    localparam int XW = (N > LOG2_WINDOW + 1 ? N : LOG2_WINDOW + 1) + 1;
    localparam logic [XW-1:0] MAXN = XW'({N{1'b1}});

    typedef enum logic [1:0] {IDLE, ACCUM, COMPUTE, STROBE} state_t;

    state_t                  r_state, w_next;
    logic [LOG2_WINDOW-1:0]  r_cnt;
    logic signed [AW-1:0]    r_acc, w_delta;
    logic [N-1:0]            r_param, w_mod;
    logic                    r_sign, w_sgn;
    logic [N_RESISTANCE-1:0] r_res, w_res;
    logic                    r_last_dir, r_last_valid;
    logic                    w_dir, w_zero, w_same, w_over;
    logic [AW-1:0]           w_abs;
    logic [XW-1:0]           w_shr, w_step, w_par, w_sum, w_mag;

    always_comb begin
        w_next = r_state;
        if (i_en)
            case (r_state)
                IDLE:    w_next = i_start ? ACCUM : IDLE;
                ACCUM:   w_next = &r_cnt ? COMPUTE : ACCUM;
                COMPUTE: w_next = STROBE;
                default: w_next = IDLE;
            endcase
    end

    assign o_trig  = (r_state == STROBE) && i_en;
    assign o_done  = o_trig;
    assign o_busy  = r_state != IDLE;
    assign w_delta = (i_grad_pos == i_grad_neg) ? '0 : i_grad_pos ? AW'(1) : '1;

    always_comb begin
        w_dir  = r_acc[AW-1];
        w_zero = r_acc == '0;
        w_abs  = w_dir ? AW'(-r_acc) : AW'(r_acc);
        // shifting by >= LOG2_WINDOW+1 naturally yields zero
        w_shr  = XW'(w_abs) >> r_res;
        w_step = w_shr > MAXN ? MAXN : w_shr;
        w_par  = XW'(r_param);
        w_sum  = w_par + w_step;
        w_same = w_dir == r_sign;
        w_over = w_step > w_par;
        w_mag  = w_same ? (w_sum > MAXN ? MAXN : w_sum) : w_over ? w_step - w_par : w_par - w_step;
        w_mod  = w_zero ? r_param : w_mag[N-1:0];
        // a crossing through zero takes the gradient's direction; exact zero is positive
        w_sgn  = w_zero ? r_sign : w_same ? r_sign : w_over ? w_dir : (w_mod == '0 ? 1'b0 : r_sign);
        // consistent direction relaxes resistance, a reversal stiffens it
        w_res  = (w_zero || !r_last_valid) ? r_res :
                 (w_dir == r_last_dir) ? (r_res == '0 ? r_res : r_res - N_RESISTANCE'(1)) :
                 (&r_res ? r_res : r_res + N_RESISTANCE'(1));
    end

    always_ff @(posedge i_clk or posedge i_init) begin
        if (i_init) begin
            r_state          <= IDLE;
            r_cnt            <= '0;
            r_acc            <= '0;
            r_param          <= '0;
            r_sign           <= 1'b0;
            r_res            <= '0;
            r_last_dir       <= 1'b0;
            r_last_valid     <= 1'b0;
            o_modifier       <= '0;
            o_sign_modifier  <= 1'b0;
            o_resistance_new <= '0;
        end else if (i_en) begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (i_start) begin
                    r_param <= i_param_in;
                    r_sign  <= i_sign_in;
                    r_res   <= i_resistance_in;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end
                ACCUM: begin
                    r_acc <= r_acc + w_delta;
                    r_cnt <= r_cnt + LOG2_WINDOW'(1);
                end
                COMPUTE: begin
                    o_modifier       <= w_mod;
                    o_sign_modifier  <= w_sgn;
                    o_resistance_new <= w_res;
                    if (!w_zero) begin
                        r_last_dir   <= w_dir;
                        r_last_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nn_param_update_calc.sv
// tb_nn_param_update_calc: directed vector bench for nn_param_update_calc (W=16).
module tb_nn_param_update_calc;
    logic       clk = 1'b0, init = 1'b1, en = 1'b0, start = 1'b0, gp = 1'b0, gn = 1'b0;
    logic [7:0] param_in = '0, res_in = '0;
    logic       sign_in = 1'b0;
    logic [7:0] modifier, res_new;
    logic       sign_mod, trig, busy, done;
    int         total = 0, bad = 0;

    nn_param_update_calc #(.N(8), .N_RESISTANCE(8), .LOG2_WINDOW(4)) dut (
        .i_clk(clk), .i_init(init), .i_en(en), .i_start(start),
        .i_grad_pos(gp), .i_grad_neg(gn), .i_param_in(param_in),
        .i_sign_in(sign_in), .i_resistance_in(res_in),
        .o_modifier(modifier), .o_sign_modifier(sign_mod), .o_resistance_new(res_new),
        .o_trig(trig), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        init;
        logic [7:0]  param;
        logic        sign;
        logic [7:0]  res;
        logic [15:0] pos;
        logic [15:0] neg;
        logic [7:0]  mod;
        logic        msign;
        logic [7:0]  mres;
    } vec_t;

    vec_t v [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic do_update(input logic [7:0] p, input logic s, input logic [7:0] r,
                             input logic [15:0] pos, input logic [15:0] neg,
                             input int hold, input bit glitch, output int lat);
        int cyc, smp;
        @(negedge clk);
        param_in = p; sign_in = s; res_in = r; start = 1'b1; en = 1'b1; gp = 1'b0; gn = 1'b0;
        cyc = 0;
        smp = 0;
        while (smp < 16) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) chk("busy_accum", busy, 1);
            start = 1'b0; param_in = p; sign_in = s;
            if (glitch && cyc == 3) begin
                start = 1'b1; param_in = 8'd200; sign_in = ~s;
            end
            if (hold != 0 && cyc >= hold && cyc < hold + 5) begin
                en = 1'b0; gp = 1'b1; gn = 1'b0;
            end else begin
                en = 1'b1; gp = pos[smp]; gn = neg[smp]; smp++;
            end
        end
        lat = -1;
        while (lat < 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            start = 1'b0; en = 1'b1; gp = 1'b0; gn = 1'b0;
            if (trig) lat = cyc;
        end
    endtask

    initial begin
        int  lat;
        bit  seen;
        // init, param, sign, res, pos, neg, expected mod, sign, res
        v[0]  = '{1'b0, 8'd10,  1'b0, 8'd0,   16'hFFFF, 16'h0000, 8'd26,  1'b0, 8'd0};
        v[1]  = '{1'b0, 8'd5,   1'b0, 8'd0,   16'h0000, 16'hFFFF, 8'd11,  1'b1, 8'd1};
        v[2]  = '{1'b0, 8'd250, 1'b0, 8'd0,   16'hFFFF, 16'h0000, 8'd255, 1'b0, 8'd1};
        v[3]  = '{1'b0, 8'd16,  1'b0, 8'd0,   16'h0000, 16'hFFFF, 8'd0,   1'b0, 8'd1};
        v[4]  = '{1'b1, 8'd10,  1'b0, 8'd2,   16'hFFFF, 16'h0000, 8'd14,  1'b0, 8'd2};
        v[5]  = '{1'b0, 8'd14,  1'b0, 8'd2,   16'hFFFF, 16'h0000, 8'd18,  1'b0, 8'd1};
        v[6]  = '{1'b0, 8'd18,  1'b0, 8'd1,   16'h0000, 16'hFFFF, 8'd10,  1'b0, 8'd2};
        v[7]  = '{1'b0, 8'd10,  1'b0, 8'd255, 16'hFFFF, 16'h0000, 8'd10,  1'b0, 8'd255};
        v[8]  = '{1'b0, 8'd3,   1'b1, 8'd0,   16'h00FF, 16'hFFFF, 8'd11,  1'b1, 8'd1};
        v[9]  = '{1'b0, 8'd77,  1'b1, 8'd9,   16'hAAAA, 16'h5555, 8'd77,  1'b1, 8'd9};
        v[10] = '{1'b0, 8'd2,   1'b1, 8'd1,   16'h000F, 16'h0000, 8'd0,   1'b0, 8'd2};
        v[11] = '{1'b0, 8'd1,   1'b1, 8'd0,   16'h0007, 16'h0000, 8'd2,   1'b0, 8'd0};

        repeat (2) @(negedge clk);
        chk("rst_mod", modifier, 0);
        chk("rst_sign", sign_mod, 0);
        chk("rst_res", res_new, 0);
        chk("rst_busy", busy, 0);
        chk("rst_trig", trig, 0);
        chk("rst_done", done, 0);
        init = 1'b0;

        for (int i = 0; i < 12; i++) begin
            if (v[i].init) begin
                @(negedge clk) init = 1'b1;
                @(negedge clk) init = 1'b0;
            end
            do_update(v[i].param, v[i].sign, v[i].res, v[i].pos, v[i].neg, 0, 1'b0, lat);
            chk($sformatf("v%0d_latency", i), lat, 18);
            chk($sformatf("v%0d_mod", i), modifier, v[i].mod);
            chk($sformatf("v%0d_sign", i), sign_mod, v[i].msign);
            chk($sformatf("v%0d_res", i), res_new, v[i].mres);
            chk($sformatf("v%0d_done", i), done, 1);
        end

        // EN freeze during ACCUM plus a START that must be ignored
        do_update(8'd20, 1'b0, 8'd1, 16'hFFFF, 16'h0000, 5, 1'b1, lat);
        chk("hold_latency", lat, 23);
        chk("hold_mod", modifier, 28);
        chk("hold_sign", sign_mod, 0);
        chk("hold_res", res_new, 0);

        // EN low while in STROBE masks TRIG/DONE and resumes afterwards
        do_update(8'd40, 1'b1, 8'd3, 16'h0000, 16'hFFFF, 0, 1'b0, lat);
        chk("strobe_latency", lat, 18);
        chk("strobe_mod", modifier, 42);
        chk("strobe_sign", sign_mod, 1);
        chk("strobe_res", res_new, 4);
        en = 1'b0;
        #1 chk("en_low_trig", trig, 0);
        chk("en_low_done", done, 0);
        @(negedge clk);
        chk("en_low_busy", busy, 1);
        chk("en_low_trig2", trig, 0);
        en = 1'b1;
        #1 chk("resume_trig", trig, 1);
        @(negedge clk);
        chk("resume_idle_busy", busy, 0);
        chk("resume_idle_trig", trig, 0);

        // INIT mid-ACCUM aborts with no TRIG
        param_in = 8'd60; sign_in = 1'b0; res_in = 8'd0; start = 1'b1; gp = 1'b1; gn = 1'b0;
        repeat (7) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("abort_busy_before", busy, 1);
        #2 init = 1'b1;
        #1 chk("abort_mod", modifier, 0);
        chk("abort_sign", sign_mod, 0);
        chk("abort_res", res_new, 0);
        chk("abort_busy", busy, 0);
        chk("abort_trig", trig, 0);
        @(negedge clk) init = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (trig || done) seen = 1'b1;
        end
        chk("abort_no_trig", seen, 0);

        // history cleared by INIT: resistance passes through unchanged
        do_update(8'd10, 1'b0, 8'd5, 16'hFFFF, 16'h0000, 0, 1'b0, lat);
        chk("post_abort_latency", lat, 18);
        chk("post_abort_mod", modifier, 10);
        chk("post_abort_res", res_new, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nn_param_update_calc.md
NN_PARAM_UPDATE_CALC -- requirements
Module: nn_param_update_calc

Interface
REQ-001 SHALL have parameter N, default 8, magnitude width of parameter and modifier.
REQ-002 SHALL have parameter N_RESISTANCE, default 8, resistance width.
REQ-003 SHALL have parameter LOG2_WINDOW, default 8; window length W = 2^LOG2_WINDOW cycles.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 INIT  input  1  reset, asynchronous, active-high.
REQ-006 EN  input  1  global enable; low freezes all state.
REQ-007 START  input  1  request one update cycle; sampled only in IDLE.
REQ-008 GRAD_POS  input  1  stochastic bit stream, positive gradient.
REQ-009 GRAD_NEG  input  1  stochastic bit stream, negative gradient.
REQ-010 PARAM_IN  input  N  current parameter magnitude, from the latched parameter register.
REQ-011 SIGN_IN  input  1  current parameter sign (1 = negative).
REQ-012 RESISTANCE_IN  input  N_RESISTANCE  current resistance, from the latched parameter register.
REQ-013 MODIFIER  output  N  new parameter magnitude, registered.
REQ-014 SIGN_MODIFIER  output  1  new parameter sign, registered.
REQ-015 RESISTANCE_NEW  output  N_RESISTANCE  new resistance, registered.
REQ-016 TRIG  output  1  one-cycle latch strobe to the parameter register.
REQ-017 BUSY  output  1  high in every state except IDLE.
REQ-018 DONE  output  1  one-cycle pulse, coincident with TRIG.

Function
REQ-019 FSM states SHALL be IDLE, ACCUM, COMPUTE, STROBE; state changes only while EN=1.
REQ-020 IDLE with START=1 and EN=1: capture PARAM_IN/SIGN_IN/RESISTANCE_IN, clear accumulator and window counter, go to ACCUM.
REQ-021 ACCUM: per cycle, signed accumulator (LOG2_WINDOW+2 bits) += GRAD_POS - GRAD_NEG; both high or both low adds 0.
REQ-022 ACCUM SHALL last exactly W sampled cycles, then go to COMPUTE.
REQ-023 COMPUTE: direction D = 1 if acc<0, else 0; step = min(|acc| >> RESISTANCE_captured, 2^N-1); shift >= LOG2_WINDOW+1 gives step=0.
REQ-024 Same sign (D==SIGN_captured): MODIFIER = min(PARAM+step, 2^N-1), SIGN_MODIFIER = SIGN_captured.
REQ-025 Opposite sign, step > PARAM: MODIFIER = step-PARAM, SIGN_MODIFIER = D.
REQ-026 Opposite sign, step <= PARAM: MODIFIER = PARAM-step, SIGN_MODIFIER = SIGN_captured; result 0 forces SIGN_MODIFIER=0.
REQ-027 acc==0: MODIFIER/SIGN_MODIFIER = captured values; RESISTANCE_NEW = captured resistance.
REQ-028 Resistance, acc!=0 and LAST_VALID=1: D==LAST_DIR -> resistance-1 saturating at 0; D!=LAST_DIR -> resistance+1 saturating at 2^N_RESISTANCE-1.
REQ-029 acc!=0 and LAST_VALID=0: RESISTANCE_NEW = captured resistance; in both cases LAST_DIR<=D, LAST_VALID<=1.
REQ-030 COMPUTE SHALL go to STROBE after one cycle; outputs change only in COMPUTE and stay stable until next COMPUTE.
REQ-031 STROBE: TRIG=1 and DONE=1 for one cycle, then IDLE; START-to-TRIG latency = W+2 cycles with EN held high.
REQ-032 EN=0: hold state, counter, accumulator, outputs; TRIG and DONE forced 0; STROBE resumes when EN returns.
REQ-033 START outside IDLE SHALL be ignored.

Reset
REQ-034 INIT=1 SHALL immediately force IDLE, MODIFIER=0, SIGN_MODIFIER=0, RESISTANCE_NEW=0, TRIG=0, BUSY=0, DONE=0, LAST_DIR=0, LAST_VALID=0, accumulator and counter 0.
REQ-035 INIT mid-operation SHALL abort the update with no TRIG issued.

Verification (LOG2_WINDOW=4, W=16, N=8, N_RESISTANCE=8)
REQ-036 PARAM_IN=10, SIGN_IN=0, RES=0, GRAD_POS=1 x16 -> MODIFIER=26, SIGN=0, RESISTANCE_NEW=0, TRIG exactly 18 cycles after START.
REQ-037 PARAM_IN=5, SIGN_IN=0, RES=0, GRAD_NEG=1 x16 -> MODIFIER=11, SIGN_MODIFIER=1.
REQ-038 PARAM_IN=250, SIGN_IN=0, RES=0, GRAD_POS=1 x16 -> MODIFIER=255; PARAM_IN=16 opposite direction -> MODIFIER=0, SIGN=0.
REQ-039 RES=2, two updates GRAD_POS x16 -> step=4, RESISTANCE_NEW 2 then 1; third with GRAD_NEG -> 2; RES=255 opposite direction -> 255.
REQ-040 INIT pulse in cycle 7 of ACCUM -> IDLE, all outputs 0, no TRIG; EN low 5 cycles during ACCUM -> TRIG at 23 cycles after START.
